// File: rtl/univ_shift_reg_pkg.sv
// Shared types and constants for the universal shift register.
// Used by univ_shift_reg and usr_bit_cell.
package univ_shift_reg_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_CLR  = 3'b111
  } mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // Shift and rotate operations advance the sequence counter.
  function automatic logic is_counted(input mode_e m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
           (m == MODE_ROR) || (m == MODE_ASR);
  endfunction

endpackage

// File: rtl/usr_bit_cell.sv
// One bit of the universal shift register: 8:1 next-value mux and a flop.
// Exposes its next value when UNIV_SHIFT_REG_PARITY_EN is defined.
module usr_bit_cell
  import univ_shift_reg_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  mode_e mode,
  input  logic  d,
  input  logic  shl_in,
  input  logic  shr_in,
  input  logic  rol_in,
  input  logic  ror_in,
  input  logic  asr_in,
`ifdef UNIV_SHIFT_REG_PARITY_EN
  output logic  nxt,
`endif
  output logic  q
);

  logic q_next;

  // NOTE: q_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    q_next = q;
    if (en) begin
      case (mode)
        MODE_HOLD: q_next = q;
        MODE_LOAD: q_next = d;
        MODE_SHL:  q_next = shl_in;
        MODE_SHR:  q_next = shr_in;
        MODE_ROL:  q_next = rol_in;
        MODE_ROR:  q_next = ror_in;
        MODE_ASR:  q_next = asr_in;
        MODE_CLR:  q_next = 1'b0;
        default:   q_next = q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all cells update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= RST_VAL;
    else     q <= q_next;
  end

`ifdef UNIV_SHIFT_REG_PARITY_EN
  assign nxt = q_next;
`endif

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with shift-sequence counter and DONE pulse.
// Optional registered parity output PAR under UNIV_SHIFT_REG_PARITY_EN.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int                 WIDTH     = 8,
  parameter int                 SHIFT_LEN = WIDTH,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sil,
  input  logic             sir,
  output logic [WIDTH-1:0] q,
  output logic             sol,
  output logic             sor,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             done
`ifdef UNIV_SHIFT_REG_PARITY_EN
  ,
  output logic             par
`endif
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SHIFT_LEN - 1);

  mode_e            op;
  state_e           state, state_next;
  logic [CNT_W-1:0] cnt_next;
  logic             done_next;

  assign op = mode_e'(mode);

`ifdef UNIV_SHIFT_REG_PARITY_EN
  logic [WIDTH-1:0] q_nxt;
`endif

  // Neighbour wiring per bit: the edges take serial inputs or wrap around.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic shl_in, shr_in, rol_in, ror_in, asr_in;

    if (i == 0) begin : g_lsb
      assign shl_in = sil;
      assign rol_in = q[WIDTH-1];
    end else begin : g_low
      assign shl_in = q[i-1];
      assign rol_in = q[i-1];
    end

    if (i == WIDTH - 1) begin : g_msb
      assign shr_in = sir;
      assign ror_in = q[0];
      assign asr_in = q[WIDTH-1];
    end else begin : g_high
      assign shr_in = q[i+1];
      assign ror_in = q[i+1];
      assign asr_in = q[i+1];
    end

    usr_bit_cell #(
      .RST_VAL (RESET_VAL[i])
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .mode   (op),
      .d      (d[i]),
      .shl_in (shl_in),
      .shr_in (shr_in),
      .rol_in (rol_in),
      .ror_in (ror_in),
      .asr_in (asr_in),
`ifdef UNIV_SHIFT_REG_PARITY_EN
      .nxt    (q_nxt[i]),
`endif
      .q      (q[i])
    );
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done_next  = 1'b0;
    if (en) begin
      if (op == MODE_LOAD) begin
        state_next = ST_ACTIVE;
        cnt_next   = '0;
      end else if (op == MODE_CLR) begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end else if (is_counted(op) && state == ST_ACTIVE) begin
        if (cnt == LAST_CNT) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      done  <= done_next;
    end
  end

`ifdef UNIV_SHIFT_REG_PARITY_EN
  // Parity of the value Q takes on this edge, so PAR and Q stay coherent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) par <= ^RESET_VAL;
    else     par <= ^q_nxt;
  end
`endif

  assign sol  = q[WIDTH-1];
  assign sor  = q[0];
  assign busy = (state == ST_ACTIVE);

endmodule
